// File: rtl/sonar_pkg.sv
// Shared types and default constants for the sonar sweep controller.
package sonar_pkg;

    localparam int DIST_W_PADRAO         = 12;
    localparam int ESPERA_CICLOS_PADRAO  = 25_000_000;
    localparam int TIMEOUT_CICLOS_PADRAO = 3_000_000;

    // Controller states; the numeric value is exported on db_estado.
    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ESPERA        = 4'd2,
        MEDE          = 4'd3,
        AGUARDA       = 4'd4,
        CALCULA       = 4'd5,
        TRANSMITE     = 4'd6,
        AGUARDA_ENVIO = 4'd7,
        PROXIMA       = 4'd8,
        FIM           = 4'd9
    } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter: counts while conta=1, wraps after M-1, fim flags M-1.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] MAXIMO = W'(M - 1);

    logic [W-1:0] valor;

    // Count register with synchronous clear taking priority over counting.
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= (valor == MAXIMO) ? '0 : valor + W'(1);
        end
    end

    assign fim = (valor == MAXIMO);

endmodule

// File: rtl/sonar_varredura.sv
// Sonar sweep controller: positions a servo, averages N_MED distance
// samples per position, transmits the average and sweeps single or ping-pong.
module sonar_varredura
    import sonar_pkg::*;
#(
    parameter int N_POS          = 8,
    parameter int N_MED          = 4,
    parameter int DIST_W         = DIST_W_PADRAO,
    parameter int ESPERA_CICLOS  = ESPERA_CICLOS_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ligar,
    input  logic                       modo,
    input  logic                       medida_pronto,
    input  logic [DIST_W-1:0]          medida,
    input  logic                       envio_pronto,
    output logic [$clog2(N_POS)-1:0]   posicao,
    output logic                       medir,
    output logic                       transmitir,
    output logic [DIST_W-1:0]          distancia,
    output logic                       erro_medida,
    output logic                       fim_posicao,
    output logic                       fim_varredura,
    output logic                       pronto,
    output logic [3:0]                 db_estado
);

    localparam int POS_W = $clog2(N_POS);
    localparam int SH    = $clog2(N_MED);
    localparam int ACC_W = DIST_W + SH;
    localparam int CNT_W = $clog2(N_MED + 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);
    localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(N_MED - 1);

    estado_t           estado, proximo;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  n_amostras;
    logic              sobe;
    logic              fim_espera, fim_timeout;
    logic              amostra_ok;
    logic [DIST_W-1:0] amostra;
    logic              vai_subir;
    logic [POS_W-1:0]  pos_seguinte;
    logic              extremo;
    logic              avanca;

    // Settle timer runs only in ESPERA; timeout timer only in AGUARDA.
    contador_m #(.M(ESPERA_CICLOS)) u_espera (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ESPERA),
        .conta (estado == ESPERA),
        .fim   (fim_espera)
    );

    contador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado != AGUARDA),
        .conta (estado == AGUARDA),
        .fim   (fim_timeout)
    );

    // Sample selection: a real measurement wins over a simultaneous timeout.
    always_comb begin
        amostra_ok = 1'b0;
        amostra    = medida;
        if (estado == AGUARDA) begin
            if (medida_pronto) begin
                amostra_ok = 1'b1;
            end else if (fim_timeout) begin
                amostra_ok = 1'b1;
                amostra    = '1;
            end
        end
    end

    // Next servo position; ping-pong turns around at either end.
    always_comb begin
        vai_subir = sobe;
        if (posicao == '0) begin
            vai_subir = 1'b1;
        end else if (posicao == POS_MAX) begin
            vai_subir = 1'b0;
        end
        if (!modo || vai_subir) begin
            pos_seguinte = posicao + POS_W'(1);
        end else begin
            pos_seguinte = posicao - POS_W'(1);
        end
        extremo = (pos_seguinte == POS_MAX) || (pos_seguinte == '0);
        avanca  = ligar && (modo || (posicao != POS_MAX));
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state and Moore outputs.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        proximo       = estado;
        medir         = 1'b0;
        transmitir    = 1'b0;
        fim_posicao   = 1'b0;
        fim_varredura = 1'b0;
        pronto        = 1'b0;
        case (estado)
            INICIAL:       if (ligar) proximo = PREPARA;
            PREPARA:       proximo = ESPERA;
            ESPERA: begin
                if (!ligar)          proximo = INICIAL;
                else if (fim_espera) proximo = MEDE;
            end
            MEDE: begin
                medir   = 1'b1;
                proximo = AGUARDA;
            end
            AGUARDA: begin
                if (amostra_ok) proximo = (n_amostras == CNT_ULT) ? CALCULA : MEDE;
            end
            CALCULA:       proximo = TRANSMITE;
            TRANSMITE: begin
                transmitir = 1'b1;
                proximo    = AGUARDA_ENVIO;
            end
            AGUARDA_ENVIO: if (envio_pronto) proximo = PROXIMA;
            PROXIMA: begin
                fim_posicao = 1'b1;
                if (!ligar) begin
                    proximo = INICIAL;
                end else if (!modo && posicao == POS_MAX) begin
                    fim_varredura = 1'b1;
                    proximo       = FIM;
                end else begin
                    fim_varredura = modo && extremo;
                    proximo       = ESPERA;
                end
            end
            FIM: begin
                pronto = 1'b1;
                if (!ligar) proximo = INICIAL;
            end
            default:       proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

    // Datapath: position, direction, accumulator, sample count, result, error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            posicao     <= '0;
            sobe        <= 1'b1;
            acc         <= '0;
            n_amostras  <= '0;
            distancia   <= '0;
            erro_medida <= 1'b0;
        end else begin
            case (estado)
                PREPARA: begin
                    posicao     <= '0;
                    sobe        <= 1'b1;
                    acc         <= '0;
                    n_amostras  <= '0;
                    erro_medida <= 1'b0;
                end
                AGUARDA: begin
                    if (amostra_ok) begin
                        acc        <= acc + ACC_W'(amostra);
                        n_amostras <= n_amostras + CNT_W'(1);
                        if (!medida_pronto) erro_medida <= 1'b1;
                    end
                end
                CALCULA: begin
                    distancia  <= DIST_W'(acc >> SH);
                    acc        <= '0;
                    n_amostras <= '0;
                end
                PROXIMA: begin
                    if (avanca) begin
                        posicao <= pos_seguinte;
                        if (modo) sobe <= vai_subir ? (pos_seguinte != POS_MAX)
                                                    : (pos_seguinte == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_varredura.sv
// Self-checking bench for sonar_varredura with a queue-based reference model.
module tb_sonar_varredura;
    import sonar_pkg::*;

    localparam int N_POS   = 4;
    localparam int N_MED   = 2;
    localparam int DIST_W  = 12;
    localparam int ESPERA  = 4;
    localparam int TIMEOUT = 20;

    logic              clock, reset, ligar, modo, medida_pronto, envio_pronto;
    logic [DIST_W-1:0] medida;
    logic [1:0]        posicao;
    logic              medir, transmitir, erro_medida, fim_posicao, fim_varredura, pronto;
    logic [DIST_W-1:0] distancia;
    logic [3:0]        db_estado;

    sonar_varredura #(
        .N_POS(N_POS), .N_MED(N_MED), .DIST_W(DIST_W),
        .ESPERA_CICLOS(ESPERA), .TIMEOUT_CICLOS(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
        .medida_pronto(medida_pronto), .medida(medida), .envio_pronto(envio_pronto),
        .posicao(posicao), .medir(medir), .transmitir(transmitir),
        .distancia(distancia), .erro_medida(erro_medida), .fim_posicao(fim_posicao),
        .fim_varredura(fim_varredura), .pronto(pronto), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model / responder state
    int   cyc = 0;
    int   med_at = -1, env_at = -1;
    logic [DIST_W-1:0] med_val;
    int   samples[$];
    int   resp_mode = 0;
    logic cur_modo = 1'b0;
    int   n_trans = 0, n_fimpos = 0, n_fimvar = 0, n_medir = 0;
    bit   erro_exp = 0, espera_pend = 0, alt = 0;
    int   mark = 0, last_medir = 0, lat_prev = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Position index of the k-th visited position in a sweep.
    function automatic int pos_model(input int k, input logic m);
        int period;
        int p;
        if (!m) return k;
        period = 2 * (N_POS - 1);
        p = k % period;
        return (p < N_POS) ? p : period - p;
    endfunction

    // One clock cycle: drive responder inputs, observe outputs, update model.
    task automatic step();
        int d;
        int v;
        int sum;
        int exp_d;
        @(posedge clock);
        #1;
        cyc++;
        medida_pronto = (cyc == med_at);
        medida        = (cyc == med_at) ? med_val : 12'($urandom);
        envio_pronto  = (cyc == env_at);
        if (db_estado == PREPARA) begin
            mark = cyc;
            espera_pend = 1'b1;
        end
        if (medir) begin
            n_medir++;
            if (espera_pend) begin
                check("espera_len", cyc - mark, ESPERA + 1);
                espera_pend = 1'b0;
            end
            if (samples.size() % N_MED != 0) check("sample_lat", cyc - last_medir, lat_prev + 1);
            case (resp_mode)
                0: begin d = 3; v = alt ? 103 : 100; alt = ~alt; end
                1: begin d = int'($urandom_range(24, 1)); v = int'($urandom_range(4095, 0)); end
                2: begin d = 99; v = 0; end
                default: begin d = TIMEOUT; v = int'($urandom_range(4095, 0)); end
            endcase
            if (d <= TIMEOUT) begin
                med_at  = cyc + d;
                med_val = 12'(v);
                samples.push_back(v);
                lat_prev = d;
            end else begin
                med_at = -1;
                samples.push_back(4095);
                erro_exp = 1'b1;
                lat_prev = TIMEOUT;
            end
            last_medir = cyc;
        end
        if (fim_posicao) begin
            check("fimpos_posicao", int'(posicao), pos_model(n_fimpos, cur_modo));
            if (cur_modo) begin
                exp_d = pos_model(n_fimpos + 1, 1'b1);
                check("fim_varredura", int'(fim_varredura), int'(exp_d == 0 || exp_d == N_POS - 1));
            end else begin
                check("fim_varredura", int'(fim_varredura), int'(pos_model(n_fimpos, 1'b0) == N_POS - 1));
            end
            n_fimpos++;
            mark = cyc;
            espera_pend = 1'b1;
        end
        if (fim_varredura) n_fimvar++;
        if (transmitir) begin
            exp_d = -1;
            if (samples.size() >= N_MED) begin
                sum = 0;
                for (int i = 0; i < N_MED; i++) sum += samples.pop_front();
                exp_d = sum / N_MED;
            end
            check("distancia", int'(distancia), exp_d);
            check("erro_medida", int'(erro_medida), int'(erro_exp));
            check("trans_posicao", int'(posicao), pos_model(n_trans, cur_modo));
            n_trans++;
            env_at = cyc + ((resp_mode == 0) ? 3 : int'($urandom_range(4, 1)));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ligar = 1'b0;
        medida_pronto = 1'b0;
        envio_pronto = 1'b0;
        med_at = -1;
        env_at = -1;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic start_run(input logic m, input int rm);
        samples.delete();
        n_trans = 0; n_fimpos = 0; n_fimvar = 0; n_medir = 0;
        erro_exp = 0; alt = 0; espera_pend = 0;
        med_at = -1; env_at = -1;
        cur_modo = m; modo = m; resp_mode = rm;
        ligar = 1'b1;
    endtask

    task automatic until_trans(input int n, input int budget, input string tag);
        int k = 0;
        while (n_trans < n && k < budget) begin step(); k++; end
        check(tag, int'(n_trans >= n), 1);
    endtask

    task automatic until_state(input estado_t s, input int budget, input string tag);
        int k = 0;
        while (db_estado != s && k < budget) begin step(); k++; end
        check(tag, int'(db_estado == s), 1);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_posicao"}, int'(posicao), 0);
        check({p, "_distancia"}, int'(distancia), 0);
        check({p, "_erro"}, int'(erro_medida), 0);
        check({p, "_pulsos"}, int'({medir, transmitir, fim_posicao, fim_varredura}), 0);
        check({p, "_pronto"}, int'(pronto), 0);
        check({p, "_db_estado"}, int'(db_estado), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m0;
        reset = 1'b0; ligar = 1'b0; modo = 1'b0;
        medida_pronto = 1'b0; envio_pronto = 1'b0; medida = '0;
        do_reset();
        check_reset_vals("reset");

        // Directed single sweep: 100/103 answered after 3 cycles.
        start_run(1'b0, 0);
        until_state(FIM, 1000, "single_to_fim");
        check("single_ntrans", n_trans, 4);
        check("single_fimpos", n_fimpos, 4);
        check("single_fimvar", n_fimvar, 1);
        check("single_pronto", int'(pronto), 1);
        check("single_dist", int'(distancia), 101);
        step();
        check("fim_holds", int'(pronto), 1);
        ligar = 1'b0;
        step();
        check("fim_to_inicial", int'(db_estado), 0);

        // Never answered: both samples time out.
        do_reset();
        start_run(1'b0, 2);
        until_trans(1, 300, "timeout_trans");
        check("timeout_dist", int'(distancia), 4095);
        check("timeout_erro", int'(erro_medida), 1);

        // Answer exactly when the timeout expires: real sample, no error.
        do_reset();
        start_run(1'b0, 3);
        until_trans(2, 400, "boundary_trans");
        check("boundary_erro", int'(erro_medida), 0);

        // Random ping-pong sweep.
        do_reset();
        start_run(1'b1, 1);
        until_trans(8, 3000, "pingpong_trans");
        check("pingpong_fimvar", n_fimvar, 2);

        // Random single sweep.
        do_reset();
        start_run(1'b0, 1);
        until_state(FIM, 3000, "rand_to_fim");
        check("rand_ntrans", n_trans, 4);
        check("rand_fimvar", n_fimvar, 1);

        // Drop ligar while waiting for the transmitter.
        do_reset();
        start_run(1'b0, 0);
        until_state(AGUARDA_ENVIO, 300, "drop_reach_envio");
        ligar = 1'b0;
        m0 = n_fimpos;
        for (int k = 0; k < 20 && n_fimpos == m0; k++) step();
        check("drop_envio_accepted", n_fimpos - m0, 1);
        step();
        check("drop_inicial", int'(db_estado), 0);
        m0 = n_medir;
        for (int k = 0; k < 30; k++) step();
        check("drop_no_medir", n_medir - m0, 0);

        // Asynchronous reset in the middle of AGUARDA.
        do_reset();
        start_run(1'b0, 0);
        until_trans(1, 300, "areset_trans");
        until_state(AGUARDA, 100, "areset_aguarda");
        check("areset_pre_dist", int'(distancia), 101);
        check("areset_pre_pos", int'(posicao), 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("areset");
        ligar = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        med_at = cyc + 1;
        med_val = 12'd500;
        step();
        step();
        step();
        check("late_state", int'(db_estado), 0);
        check("late_dist", int'(distancia), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
